// File: rtl/rglib_unrotate.sv
// rglib_unrotate: pipelined right-rotator that undoes the forward rotate unit.
// Stage k rotates right by (2**k) mod DATA_WIDTH when bit k of the amount is set.
// Valid/ready handshake on both sides; stalled stages hold, bubbles collapse.
module rglib_unrotate #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ROTATE_STAGE_NUM = 5
) (
  input  logic                        clk,
  input  logic                        kill_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in,
  input  logic [ROTATE_STAGE_NUM-1:0] rotate_val,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out
);

  localparam int unsigned W = DATA_WIDTH;
  localparam int unsigned N = ROTATE_STAGE_NUM;

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("rglib_unrotate: DATA_WIDTH must be >= 2");
  end
  if (ROTATE_STAGE_NUM < 1) begin : g_bad_stages
    $error("rglib_unrotate: ROTATE_STAGE_NUM must be >= 1");
  end

  // Per-stage registers; amount is shifted down one bit per stage so that
  // stage k always inspects bit 0 of what it receives.
  logic [N-1:0]         valid_q, valid_d;
  logic [N-1:0][W-1:0]  data_q,  data_d;
  logic [N-1:0][N-1:0]  amt_q,   amt_d;
  logic [N-1:0]         adv;
  logic                 amt_unused;

  // Last stage's remaining amount is always consumed; nothing reads it.
  assign amt_unused = ^amt_q[N-1];

  function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input int unsigned s);
    logic [2*W-1:0] dd;
    dd = {d, d} >> s;
    return dd[W-1:0];
  endfunction

  // Stage advance: closed form of adv_k = ~valid_k | adv_{k+1}, i.e. a stage
  // stalls only when it and every stage after it are full and out_ready is low.
  always_comb begin
    logic full;
    adv = '0;
    for (int unsigned k = 0; k < N; k++) begin
      full = 1'b1;
      for (int unsigned j = k; j < N; j++) begin
        full = full & valid_q[j];
      end
      adv[k] = out_ready | ~full;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[N-1];
  assign out       = data_q[N-1];

  // Next-state: each advancing stage loads from its predecessor and applies its rotate bit.
  always_comb begin
    int unsigned    step;
    logic           src_v;
    logic [W-1:0]   src_d;
    logic [N-1:0]   src_a;
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    step    = 1 % W;
    for (int unsigned k = 0; k < N; k++) begin
      if (k == 0) begin
        src_v = in_valid & adv[0];
        src_d = in;
        src_a = rotate_val;
      end else begin
        src_v = valid_q[k-1];
        src_d = data_q[k-1];
        src_a = amt_q[k-1];
      end
      if (adv[k]) begin
        valid_d[k] = src_v;
        data_d[k]  = src_a[0] ? rotr(src_d, step) : src_d;
        amt_d[k]   = src_a >> 1;
      end
      step = (step * 2) % W;
    end
  end

  // Stage registers; kill_n clears everything asynchronously.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      valid_q <= '0;
      data_q  <= '0;
      amt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
    end
  end

endmodule

// File: tb/tb_rglib_unrotate.sv
module tb_rglib_unrotate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        kill_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in, a_out;
  logic [4:0]  a_rot;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [23:0] b_in, b_out;
  logic [4:0]  b_rot;

  int checks   = 0;
  int failures = 0;

  rglib_unrotate #(.DATA_WIDTH(32), .ROTATE_STAGE_NUM(5)) u_dut32 (
    .clk(clk), .kill_n(kill_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in), .rotate_val(a_rot),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out)
  );

  rglib_unrotate #(.DATA_WIDTH(24), .ROTATE_STAGE_NUM(5)) u_dut24 (
    .clk(clk), .kill_n(kill_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in), .rotate_val(b_rot),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Forward rotator model: rotate left by r.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned r);
    logic [63:0] t;
    t = {x, x} << r;
    return t[63:32];
  endfunction

  logic [31:0] sb[$];
  logic [31:0] orig[6];
  int unsigned rots[6];

  initial begin
    logic        seen;
    logic [31:0] cur_orig;
    logic [4:0]  cur_rot;
    logic        have;
    int          sent, got, cyc;

    kill_n = 1'b0;
    a_in_valid = 1'b0; a_in = '0; a_rot = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in = '0; b_rot = '0; b_out_ready = 1'b1;
    repeat (3) tick();
    kill_n = 1'b1;
    tick();

    chk("reset_out_valid", a_out_valid, 0);
    chk("reset_out", a_out, 0);
    chk("reset_in_ready", a_in_ready, 1);

    // Single word, latency 5; 24-bit instance with rot 25 alongside.
    a_in = 32'h0000_0001; a_rot = 5'd1; a_in_valid = 1'b1;
    b_in = 24'h00_0001;   b_rot = 5'd25; b_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    repeat (3) tick();
    chk("t1_not_yet", a_out_valid, 0);
    tick();
    chk("t1_valid", a_out_valid, 1);
    chk("t1_out", a_out, 32'h8000_0000);
    chk("t6_valid", b_out_valid, 1);
    chk("t6_out", b_out, 24'h80_0000);
    tick();
    chk("t1_drained", a_out_valid, 0);

    a_in = 32'hDEAD_BEEF; a_rot = 5'd0; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    chk("t1_rot0_valid", a_out_valid, 1);
    chk("t1_rot0_out", a_out, 32'hDEAD_BEEF);
    tick();

    // Back-to-back words, no gaps.
    a_in = 32'h1234_5678; a_in_valid = 1'b1;
    a_rot = 5'd4;  tick();
    a_rot = 5'd8;  tick();
    a_rot = 5'd31; tick();
    a_in_valid = 1'b0;
    repeat (2) tick();
    chk("t2_w0_valid", a_out_valid, 1);
    chk("t2_w0", a_out, 32'h8123_4567);
    tick();
    chk("t2_w1_valid", a_out_valid, 1);
    chk("t2_w1", a_out, 32'h7812_3456);
    tick();
    chk("t2_w2_valid", a_out_valid, 1);
    chk("t2_w2", a_out, 32'h2468_ACF0);
    tick();
    chk("t2_drained", a_out_valid, 0);

    // Fill under stall, hold 10 cycles, then release with a sixth word pending.
    for (int i = 0; i < 6; i++) begin
      orig[i] = 32'h1357_9BDF ^ (32'h1111_1111 * (i + 1));
      rots[i] = (i * 7 + 3) % 32;
    end
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_fill_ready", a_in_ready, 1);
      a_in = rotl(orig[i], rots[i]); a_rot = 5'(rots[i]); a_in_valid = 1'b1;
      tick();
    end
    a_in = rotl(orig[5], rots[5]); a_rot = 5'(rots[5]);
    #1;
    chk("t3_full_ready", a_in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", a_out_valid, 1);
      chk("t3_hold_out", a_out, orig[0]);
      chk("t3_hold_ready", a_in_ready, 0);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("t3_release_ready", a_in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("t3_drain_valid", a_out_valid, 1);
      chk("t3_drain_out", a_out, orig[i]);
      tick();
      a_in_valid = 1'b0;
    end
    chk("t3_empty", a_out_valid, 0);

    // Asynchronous kill with 3 words in flight.
    for (int i = 0; i < 3; i++) begin
      a_in = rotl(orig[i], rots[i]); a_rot = 5'(rots[i]); a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    repeat (2) tick();
    chk("t4_pre_valid", a_out_valid, 1);
    #2 kill_n = 1'b0;
    #1;
    chk("t4_async_valid", a_out_valid, 0);
    chk("t4_async_out", a_out, 0);
    #1 kill_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | a_out_valid;
    end
    chk("t4_none_emerge", seen, 0);
    chk("t4_ready", a_in_ready, 1);
    a_in = 32'h0000_00F0; a_rot = 5'd4; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    chk("t4_new_not_yet", a_out_valid, 0);
    tick();
    chk("t4_new_valid", a_out_valid, 1);
    chk("t4_new_out", a_out, 32'h0000_000F);
    tick();

    // Random round trip with backpressure.
    sent = 0; got = 0; cyc = 0; have = 1'b0;
    cur_orig = '0; cur_rot = '0;
    while ((sent < 10000 || sb.size() != 0) && cyc < 40000) begin
      if (!have && sent < 10000) begin
        cur_orig = $urandom;
        cur_rot  = 5'($urandom_range(0, 31));
        have     = 1'b1;
      end
      a_in_valid  = have && ($urandom_range(0, 9) < 7);
      a_in        = rotl(cur_orig, cur_rot);
      a_rot       = cur_rot;
      a_out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (a_out_valid && a_out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          chk("rnd_word", a_out, sb.pop_front());
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        sb.push_back(cur_orig);
        sent++;
        have = 1'b0;
      end
      tick();
      cyc++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    chk("rnd_in_budget", (cyc < 40000), 1);
    chk("rnd_count", got, sent);
    chk("rnd_sent", sent, 10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
